// File: rtl/quad_decoder_px_pkg.sv
// Shared definitions for the quadrature decoder.
//   QUAD_X1/X2/X4 : encodings of the runtime 'mode' input (3 also means x4).
//   prime_cycles(): number of post-reset cycles the input path needs before
//                   its filtered outputs reflect the pins.
package quad_pkg;

  localparam logic [1:0] QUAD_X1 = 2'd0;
  localparam logic [1:0] QUAD_X2 = 2'd1;
  localparam logic [1:0] QUAD_X4 = 2'd2;

  function automatic int prime_cycles(input int sync_stages, input int filter_len);
    return sync_stages + filter_len + 1;
  endfunction

endpackage

// File: rtl/quad_decoder_px_filter.sv
// Per-pin input conditioning: synchroniser chain followed by a glitch filter.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_raw        : asynchronous pin
//   o_filt       : registered, synchronised and debounced level
// The output flips only after the synchronised value has disagreed with the
// stable level for FILTER_LEN consecutive cycles; FILTER_LEN = 0 bypasses
// the filter but keeps the output register so latency stays S+F+1 overall.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  output logic o_filt
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sync;
  logic                   r_out;

  assign w_sync = r_sync[SYNC_STAGES-1];
  assign o_filt = r_out;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_sync <= '0;
    else       r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
  end

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      always_ff @(posedge i_clk) begin
        if (i_rst) r_out <= 1'b0;
        else       r_out <= w_sync;
      end
    end else begin : g_filter
      localparam logic [7:0] RUN_LAST = 8'(FILTER_LEN - 1);
      logic [7:0] r_run;
      logic       r_stable;

      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_run    <= '0;
          r_stable <= 1'b0;
          r_out    <= 1'b0;
        end else begin
          r_out <= r_stable;
          // Any sample matching the stable level restarts the run.
          if (w_sync == r_stable) begin
            r_run <= '0;
          end else if (r_run == RUN_LAST) begin
            r_stable <= w_sync;
            r_run    <= '0;
          end else begin
            r_run <= r_run + 8'd1;
          end
        end
      end
    end
  endgenerate

endmodule

// File: rtl/quad_decoder_px.sv
// Quadrature decoder with configurable counter width, input filtering,
// runtime x1/x2/x4 mode, illegal-transition flag, index latch/clear and load.
//   clk, rst               : clock, synchronous active-high reset
//   quad_A/B/Z             : raw encoder pins (asynchronous)
//   mode                   : 0 x1, 1 x2, 2/3 x4
//   index_en, index_clr_en : index capture enable, index zeroes count
//   load, load_value       : one-cycle software load of the count
//   err_clr                : clears sticky err
//   count, dir, step       : position, last counted direction, step pulse
//   err                    : sticky illegal-transition flag
//   index_count/valid      : count captured at index edge, capture pulse
import quad_pkg::*;

module quad_decoder_px #(
  parameter int COUNT_W     = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               quad_A,
  input  logic               quad_B,
  input  logic               quad_Z,
  input  logic [1:0]         mode,
  input  logic               index_en,
  input  logic               index_clr_en,
  input  logic               load,
  input  logic [COUNT_W-1:0] load_value,
  input  logic               err_clr,
  output logic [COUNT_W-1:0] count,
  output logic               dir,
  output logic               step,
  output logic               err,
  output logic [COUNT_W-1:0] index_count,
  output logic               index_valid
);

  localparam int PRIME_CYCLES = prime_cycles(SYNC_STAGES, FILTER_LEN);
  localparam int PW           = $clog2(PRIME_CYCLES + 1);
  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  logic         w_fa, w_fb, w_fz;
  logic [1:0]   w_cur, w_chg;
  logic [1:0]   r_prev;
  logic         r_z_prev;
  logic [PW-1:0] r_prime;
  logic         r_live;
  logic         w_valid, w_illegal, w_up, w_qual;
  logic         w_step, w_step_apply, w_zrise;

  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_a (
    .i_clk(clk), .i_rst(rst), .i_raw(quad_A), .o_filt(w_fa));
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_b (
    .i_clk(clk), .i_rst(rst), .i_raw(quad_B), .o_filt(w_fb));
  quad_input_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_filt_z (
    .i_clk(clk), .i_rst(rst), .i_raw(quad_Z), .o_filt(w_fz));

  assign w_cur     = {w_fa, w_fb};
  assign w_chg     = w_cur ^ r_prev;
  assign w_valid   = ^w_chg;          // exactly one phase moved
  assign w_illegal = &w_chg;          // both phases moved at once
  assign w_up      = w_cur[1] ^ r_prev[0];

  always_comb begin
    w_qual = w_valid;
    case (mode)
      QUAD_X1: w_qual = w_valid & w_chg[1] & w_cur[1];
      QUAD_X2: w_qual = w_valid & w_chg[1];
      default: w_qual = w_valid;
    endcase
  end

  assign w_step       = r_live & w_qual;
  assign w_step_apply = w_step & ~load;   // a load overrides the step entirely
  assign w_zrise      = r_live & index_en & w_fz & ~r_z_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= 2'b00;
      r_z_prev    <= 1'b0;
      r_prime     <= PW'(PRIME_CYCLES);
      r_live      <= 1'b0;
      count       <= '0;
      dir         <= 1'b0;
      step        <= 1'b0;
      err         <= 1'b0;
      index_count <= '0;
      index_valid <= 1'b0;
    end else begin
      // prev always follows the filtered pins, so priming needs no special path.
      r_prev   <= w_cur;
      r_z_prev <= w_fz;
      if (r_prime != '0) r_prime <= r_prime - PW'(1);
      // Live one edge after the countdown ends: prev has then absorbed the
      // first filtered sample of the pins present at reset release.
      r_live <= (r_prime == '0);

      step <= w_step_apply;
      if (w_step_apply) dir <= w_up;

      index_valid <= w_zrise;
      if (w_zrise) index_count <= count;

      if (load)                         count <= load_value;
      else if (w_zrise && index_clr_en) count <= '0;
      else if (w_step)                  count <= w_up ? count + CNT_ONE : count - CNT_ONE;

      if (r_live && w_illegal) err <= 1'b1;
      else if (err_clr)        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quad_decoder_px.sv
module tb_quad_decoder_px;

  localparam int S     = 2;
  localparam int F     = 3;
  localparam int DLY   = S + 2;       // filter decision -> decoder input
  localparam int PRIME = S + F + 2;   // edges after reset with decoding held off

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        quad_A = 1'b0, quad_B = 1'b0, quad_Z = 1'b0;
  logic [1:0]  mode = 2'd2;
  logic        index_en = 1'b0, index_clr_en = 1'b0, load = 1'b0, err_clr = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] count, index_count;
  logic        dir, step, err, index_valid;

  quad_decoder_px #(.COUNT_W(16), .SYNC_STAGES(S), .FILTER_LEN(F)) dut (
    .clk(clk), .rst(rst), .quad_A(quad_A), .quad_B(quad_B), .quad_Z(quad_Z),
    .mode(mode), .index_en(index_en), .index_clr_en(index_clr_en),
    .load(load), .load_value(load_value), .err_clr(err_clr),
    .count(count), .dir(dir), .step(step), .err(err),
    .index_count(index_count), .index_valid(index_valid));

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, t_edge = 0, nsteps = 0, nival = 0;
  bit started = 0, lat_on = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] hr[3], hf[3];
  logic        mf[3];
  logic [1:0]  m_prev;
  logic        m_zprev;
  logic [15:0] m_count, m_icnt;
  logic        m_dir, m_step, m_err, m_ival;
  int          k;

  function automatic int gidx(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [2:0] raw, cur;
    logic [1:0] cab;
    int d;
    logic live, up, valid, ill, qual, zr, doit;
    cyc++;
    started = 1;
    if (rst) begin
      k = 0;
      for (int i = 0; i < 3; i++) begin hr[i] = '0; hf[i] = '0; mf[i] = 1'b0; end
      m_prev = 2'b00; m_zprev = 1'b0;
      m_count = '0; m_icnt = '0; m_dir = 0; m_step = 0; m_err = 0; m_ival = 0;
    end else begin
      k++;
      raw = {quad_A, quad_B, quad_Z};
      for (int i = 0; i < 3; i++) begin
        // level accepted once the last F samples all disagree with it
        hr[i] = {hr[i][30:0], raw[2-i]};
        if (hr[i][F-1:0] == {F{~mf[i]}}) mf[i] = ~mf[i];
        hf[i] = {hf[i][30:0], mf[i]};
        cur[2-i] = hf[i][DLY];
      end
      cab   = cur[2:1];
      live  = (k > PRIME);
      d     = (gidx(cab) - gidx(m_prev) + 4) % 4;
      up    = (d == 1);
      valid = (d == 1) || (d == 3);
      ill   = (d == 2);
      if (mode == 2'd0)      qual = valid && (cab[1] != m_prev[1]) && cab[1];
      else if (mode == 2'd1) qual = valid && (cab[1] != m_prev[1]);
      else                   qual = valid;
      doit = live && qual;
      zr   = live && index_en && cur[0] && !m_zprev;
      m_ival = zr;
      if (zr) m_icnt = m_count;
      m_step = doit && !load;
      if (m_step) m_dir = up;
      if (load)                    m_count = load_value;
      else if (zr && index_clr_en) m_count = '0;
      else if (doit)               m_count = up ? m_count + 16'd1 : m_count - 16'd1;
      if (live && ill)  m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
      m_prev  = cab;
      m_zprev = cur[0];
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), 32'(m_count));
      chk("dir", 32'(dir), 32'(m_dir));
      chk("step", 32'(step), 32'(m_step));
      chk("err", 32'(err), 32'(m_err));
      chk("index_count", 32'(index_count), 32'(m_icnt));
      chk("index_valid", 32'(index_valid), 32'(m_ival));
      if (step) nsteps++;
      if (index_valid) nival++;
      if (lat_on && step) chk("step_latency", 32'(cyc - t_edge), 32'd6);
    end
  end

  // ---------------- stimulus ----------------
  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int p = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ab(input logic a, input logic b, input int hold);
    quad_A = a; quad_B = b; t_edge = cyc + 1;
    tick(hold);
  endtask

  task automatic fwd(input int n);
    for (int i = 0; i < n; i++) begin p = (p + 1) % 4; set_ab(gray[p][1], gray[p][0], 10); end
  endtask

  task automatic rev(input int n);
    for (int i = 0; i < n; i++) begin p = (p + 3) % 4; set_ab(gray[p][1], gray[p][0], 10); end
  endtask

  task automatic do_load(input logic [15:0] v);
    load_value = v; load = 1'b1; tick(1); load = 1'b0; tick(1);
  endtask

  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] mdl, input logic [31:0] exp);
    chk(nm, act, exp);
    chk({nm, "_model"}, mdl, exp);
  endtask

  initial begin
    int s0, i0;
    // Reset with both phases high, then release: no spurious count or err.
    quad_A = 1; quad_B = 1;
    tick(3);
    lit("rst_count", 32'(count), 32'(m_count), 0);
    lit("rst_err", 32'(err), 32'(m_err), 0);
    rst = 0;
    tick(20);
    lit("prime_count", 32'(count), 32'(m_count), 0);
    lit("prime_err", 32'(err), 32'(m_err), 0);
    chk("prime_steps", 32'(nsteps), 0);

    // Restart with pins low.
    quad_A = 0; quad_B = 0; rst = 1; tick(2); rst = 0; tick(12); p = 0;

    // x4: 8 forward cycles then 12 reverse transitions.
    mode = 2'd2; s0 = nsteps; lat_on = 1;
    fwd(32);
    lit("x4_fwd_count", 32'(count), 32'(m_count), 32);
    lit("x4_fwd_dir", 32'(dir), 32'(m_dir), 1);
    rev(12);
    lat_on = 0;
    lit("x4_rev_count", 32'(count), 32'(m_count), 20);
    lit("x4_rev_dir", 32'(dir), 32'(m_dir), 0);
    chk("x4_step_total", 32'(nsteps - s0), 44);

    // x2 and x1.
    do_load(16'd0); mode = 2'd1; fwd(16);
    lit("x2_count", 32'(count), 32'(m_count), 8);
    do_load(16'd0); mode = 2'd0; fwd(16);
    lit("x1_fwd_count", 32'(count), 32'(m_count), 4);
    rev(16);
    lit("x1_rev_count", 32'(count), 32'(m_count), 0);

    // Glitches on A in x4 starting from 00.
    mode = 2'd2; s0 = nsteps;
    set_ab(1, 0, 2); set_ab(0, 0, 12);
    chk("glitch2_steps", 32'(nsteps - s0), 0);
    lit("glitch2_count", 32'(count), 32'(m_count), 0);
    set_ab(1, 0, 3); set_ab(0, 0, 12);
    chk("glitch3_steps", 32'(nsteps - s0), 2);
    lit("glitch3_count", 32'(count), 32'(m_count), 0);

    // Illegal transitions and err clear.
    set_ab(1, 1, 10);
    lit("illegal_err", 32'(err), 32'(m_err), 1);
    lit("illegal_count", 32'(count), 32'(m_count), 0);
    err_clr = 1; tick(1); err_clr = 0; tick(1);
    lit("errclr", 32'(err), 32'(m_err), 0);
    set_ab(0, 0, 6); err_clr = 1; tick(1); err_clr = 0; tick(3);
    lit("errclr_collide", 32'(err), 32'(m_err), 1);
    err_clr = 1; tick(1); err_clr = 0; tick(1); p = 0;

    // Wrap both ways.
    do_load(16'h7FFF); fwd(1);
    lit("wrap_up", 32'(count), 32'(m_count), 32'h8000);
    do_load(16'h0000); rev(1);
    lit("wrap_down", 32'(count), 32'(m_count), 32'hFFFF);

    // Index rising with clear, coincident with an up step.
    do_load(16'd100); index_en = 1; index_clr_en = 1; i0 = nival;
    quad_Z = 1; fwd(1);
    lit("index_count", 32'(index_count), 32'(m_icnt), 100);
    lit("index_clr_count", 32'(count), 32'(m_count), 0);
    chk("index_pulses", 32'(nival - i0), 1);
    quad_Z = 0; tick(10);
    index_en = 0; index_clr_en = 0;

    // Randomised traffic against the model.
    for (int it = 0; it < 500; it++) begin
      int hold;
      hold = $urandom_range(1, 9);
      if ($urandom_range(0, 3) != 0) begin
        p = ($urandom_range(0, 1) != 0) ? (p + 1) % 4 : (p + 3) % 4;
        quad_A = gray[p][1]; quad_B = gray[p][0];
      end else begin
        quad_A = 1'($urandom); quad_B = 1'($urandom);
        p = gidx({quad_A, quad_B});
      end
      if ($urandom_range(0, 5) == 0) quad_Z = ~quad_Z;
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      index_en     = ($urandom_range(0, 2) != 0);
      index_clr_en = ($urandom_range(0, 3) == 0);
      load_value   = 16'($urandom);
      load         = ($urandom_range(0, 24) == 0);
      err_clr      = ($urandom_range(0, 7) == 0);
      rst          = ($urandom_range(0, 149) == 0);
      tick(1);
      load = 0; err_clr = 0; rst = 0;
      tick(hold);
    end
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/quad_decoder_px.md
Name: quad_decoder_px

Overview:
- Parametrised quadrature decoder, successor to the 8-bit fixed-function decoder.
- Adds:
  - configurable counter width;
  - synchroniser depth and glitch filter;
  - runtime x1/x2/x4 mode;
  - illegal-transition detection;
  - index (Z) latch/clear;
  - software load.
- Sits between raw encoder pins and a register-mapped position interface, one instance per encoder.

Parameters:
- COUNT_W, 16, position counter width in bits (two's complement, 2..32).
- SYNC_STAGES, 2, synchroniser flops per input (>=2).
- FILTER_LEN, 3, consecutive stable cycles required before a filtered input changes (0 = filter bypass, max 255).

Ports:
- clk, input, 1: single clock, all logic on rising edge.
- rst, input, 1: synchronous, active-high reset.
- quad_A, input, 1: raw encoder phase A, asynchronous.
- quad_B, input, 1: raw encoder phase B, asynchronous.
- quad_Z, input, 1: raw index pulse, asynchronous.
- mode, input, 2: 0 = x1, 1 = x2, 2/3 = x4.
- index_en, input, 1: enable index latch.
- index_clr_en, input, 1: index rising edge also zeroes count.
- load, input, 1: single-cycle pulse, count <= load_value.
- load_value, input, COUNT_W: value for load.
- err_clr, input, 1: clears err.
- count, output, COUNT_W: position.
- dir, output, 1: direction of last counted step (1 = up).
- step, output, 1: one-cycle pulse when count changed due to a step.
- err, output, 1: sticky illegal-transition flag.
- index_count, output, COUNT_W: count captured at last index edge.
- index_valid, output, 1: one-cycle pulse on capture.

Behaviour:
- Reset: all sync/filter flops 0, prev state 00, count 0, dir 0, step 0, err 0, index_count 0, index_valid 0. Reset mid-operation aborts everything identically.
- Input path per signal (A, B, Z):
  - SYNC_STAGES flop chain.
  - Filter: a filtered output flips only after the synchronised value has differed from it for FILTER_LEN consecutive cycles. Any return to the old value restarts the run counter.
- Latency: a clean level change on a raw pin that is set up before edge n reaches count at edge n + SYNC_STAGES + FILTER_LEN + 1. For the default parameters this is 6 cycles.
- Priming:
  - For SYNC_STAGES + FILTER_LEN + 1 cycles after rst deasserts, prev state tracks the filtered {A,B} with no counting, no err and no index.
  - This prevents false steps when pins are non-zero at reset release.
- Decode: prev = registered filtered {A,B}; cur = filtered {A,B}.
  - No change: nothing.
  - Exactly one phase changed: valid transition. Direction up = curA ^ prevB. Forward sequence 00→10→11→01→00 counts up.
  - Both phases changed: illegal. err <= 1, no count, dir unchanged.
- Mode qualification of valid transitions:
  - x4: every valid transition.
  - x2: only transitions where A changed.
  - x1: only A rising edges (up if B=0, down if B=1).
- Counter: ±1 modulo 2^COUNT_W. Wraps silently: 0x7FFF+1 = 0x8000, 0x0000−1 = 0xFFFF.
- dir: updated only on counted steps.
- step: 1 for exactly the cycle the step applies, including when an index clear overrides it.
- Index:
  - A filtered Z rising edge with index_en=1 gives index_count <= count before this cycle's update, and index_valid pulses.
  - If index_clr_en is also 1, count <= 0.
  - index_en=0: Z ignored.
- Count priority in one cycle: rst > load > index clear > step.
- err: set by an illegal transition, cleared by err_clr. A simultaneous set and clear leaves err = 1.
- mode changes take effect on the next decoded transition; no state is flushed.

Decomposition:
- Package quad_pkg:
  - mode constants QUAD_X1 = 2'd0, QUAD_X2 = 2'd1, QUAD_X4 = 2'd2;
  - localparam PRIME_CYCLES function.
- Sub-module quad_input_filter (sync chain + stability counter, params SYNC_STAGES/FILTER_LEN), instantiated three times for A, B and Z.
- Decode, counter and index logic stay in the top level.

Test Plan:
- Reset with quad_A = quad_B = 1 held, then release: count stays 0 and err stays 0 through priming and after.
- mode=x4, 8 forward cycles (32 transitions, each level held 10 clk), then 12 reverse transitions. Required response: count = 32 with dir = 1 after the forward part, then count = 20 with dir = 0; 44 step pulses total; each step appears exactly 6 clk after its pin edge.
- 4 forward cycles: mode=x2 gives count 8; mode=x1 gives count 4. Then 4 reverse cycles in x1 returns count to 0.
- Glitches:
  - A glitch high for 2 clk gives no step and count unchanged.
  - A high for 3 clk then low gives +1 then −1 (x4).
  - Both cases with FILTER_LEN = 3.
- Illegal transition and err clear:
  - Filtered state 00 driven directly to 11 gives err = 1 with count unchanged.
  - err_clr gives err = 0.
  - err_clr in the same cycle as a new illegal transition gives err = 1.
- Wrap, load and index:
  - load 0x7FFF, then one forward step: count = 0x8000.
  - load 100, then Z rising with index_en = index_clr_en = 1 coincident with an up step: index_count = 100, count = 0, index_valid pulses once.
